// File: rtl/macc_seq.sv
// macc_seq: dot-product sequencer around one signed multiply-accumulate path.
//
// A start command carries a beat count. The block then takes that many signed
// (a, b) operand pairs over a valid/ready handshake and accumulates sum(a*b).
// The sum is then offered over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      command strobe, sampled only while idle
//   len        unsigned beat count, sampled with start (0 = empty vector)
//   abort      synchronous cancel, highest priority, any state
//   in_valid   operand pair valid
//   in_ready   operand pair accepted when in_valid & in_ready
//   a, b       signed operands
//   res_valid  result valid (held until res_ready)
//   res_ready  consumer accepts result
//   res        signed accumulated result
//   busy       high while running or holding a result
//   stall_cnt  (only with MACC_SEQ_STALL_CNT_EN) RUN cycles with in_valid low,
//              saturating at 16'hFFFF and cleared on each accepted start
//
// Optional feature macro: MACC_SEQ_STALL_CNT_EN

module macc_seq #(
  parameter  int A_WIDTH   = 4,
  parameter  int B_WIDTH   = 3,
  parameter  int LEN_WIDTH = 4,
  localparam int ACC_WIDTH = A_WIDTH + B_WIDTH + LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [ACC_WIDTH-1:0] res,
  output logic                        busy
`ifdef MACC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [LEN_WIDTH-1:0]         w_cnt_next;

  // Both operands are sign-extended to the full accumulator width before the
  // multiply. The low ACC_WIDTH bits of the product are then exact.
  logic signed [ACC_WIDTH-1:0]  w_a_ext;
  logic signed [ACC_WIDTH-1:0]  w_b_ext;
  logic signed [ACC_WIDTH-1:0]  w_prod;

  assign w_a_ext = {{(ACC_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
  assign w_b_ext = {{(ACC_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    if (abort) begin
      // Cancel wins over everything, including a beat presented this cycle.
      w_state_next = S_IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_acc_next = '0;
            if (len != '0) begin
              w_cnt_next   = len;
              w_state_next = S_RUN;
            end else begin
              w_state_next = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (in_valid) begin
            w_acc_next = r_acc + w_prod;
            w_cnt_next = r_cnt - LEN_WIDTH'(1);
            if (r_cnt == LEN_WIDTH'(1)) begin
              w_state_next = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // The result comes straight from the accumulator register. It only changes
  // on beats, so it is stable for as long as the result is held.
  assign in_ready  = (r_state == S_RUN);
  assign res_valid = (r_state == S_DONE);
  assign res       = r_acc;
  assign busy      = (r_state != S_IDLE);

`ifdef MACC_SEQ_STALL_CNT_EN
  logic        r_stall_cnt;
  logic [15:0] r_stall_val;
  logic        w_start_accept;

  assign w_start_accept = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_val <= '0;
    end else if (w_start_accept) begin
      r_stall_val <= '0;
    end else if ((r_state == S_RUN) && !in_valid && (r_stall_val != 16'hFFFF)) begin
      r_stall_val <= r_stall_val + 16'd1;
    end
  end

  assign r_stall_cnt = 1'b0;
  assign stall_cnt   = r_stall_val;
`endif

endmodule
